// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF response collector:
// controller state encoding, LFSR tap positions and counter widths.
package puf_pkg;

    // Controller states: idle, launch edge high, launch edge low, pack one bit, present word
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RISE = 3'd1,
        ST_FALL = 3'd2,
        ST_PACK = 3'd3,
        ST_OUT  = 3'd4
    } puf_state_e;

    // Feedback taps of the challenge LFSR for a 65-bit arbiter chain
    localparam int PUF_TAP_A = 64;
    localparam int PUF_TAP_B = 46;

    // Vote counter holds up to 15 evaluations; phase counter covers SETTLE_CYC+2 up to 257
    localparam int VOTE_W = 4;
    localparam int CYC_W  = 9;

    // Saturation ceiling of the optional instability counter
    localparam logic [7:0] UNSTABLE_MAX = 8'hFF;

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchroniser bringing the asynchronous arbiter decision into the clk domain.
module puf_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values simply shift the input down the two-stage chain
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages clear asynchronously so no stale decision survives reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: drives challenges and launch edges into an
// arbiter chain, majority-votes NUM_EVAL evaluations per challenge, steps the
// challenge LFSR after each bit and packs RESP_BITS bits into one output word.
// Optional feature macro: PUF_RESP_STABILITY_EN adds the unstable_cnt output,
// counting challenges per word whose evaluations did not all agree.
module puf_response_collector
    import puf_pkg::*;
#(
    parameter int CHAL_W     = 65,
    parameter int SETTLE_CYC = 4,
    parameter int NUM_EVAL   = 7,
    parameter int RESP_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAL_W-1:0]    seed,
    output logic [CHAL_W-1:0]    chal_out,
    output logic                 launch,
    input  logic                 arb_in,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready
`ifdef PUF_RESP_STABILITY_EN
    ,
    output logic [7:0]           unstable_cnt
`endif
);

    localparam int BIDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    // Taps fall back to in-range positions if the chain is narrower than 65
    localparam int TAP_HI = (PUF_TAP_A < CHAL_W) ? PUF_TAP_A : CHAL_W - 1;
    localparam int TAP_LO = (PUF_TAP_B < CHAL_W) ? PUF_TAP_B : 0;

    localparam logic [CYC_W-1:0]  RISE_LAST = CYC_W'(SETTLE_CYC + 1);
    localparam logic [CYC_W-1:0]  FALL_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [VOTE_W-1:0] EVAL_LAST = VOTE_W'(NUM_EVAL - 1);
    localparam logic [VOTE_W-1:0] VOTE_ALL  = VOTE_W'(NUM_EVAL);
    localparam logic [VOTE_W-1:0] MAJORITY  = VOTE_W'(NUM_EVAL / 2);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(RESP_BITS - 1);

    puf_state_e               state_q, state_d;
    logic [CHAL_W-1:0]        chal_q, chal_d;
    logic [CYC_W-1:0]         cyc_q, cyc_d;
    logic [VOTE_W-1:0]        eval_q, eval_d;
    logic [VOTE_W-1:0]        vote_q, vote_d;
    logic [BIDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [RESP_BITS-1:0]     data_q, data_d;
    logic                     arb_sync;
    logic [CHAL_W-1:0]        lfsr_next;

    puf_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (arb_in),
        .q     (arb_sync)
    );

    assign lfsr_next = {chal_q[CHAL_W-2:0], chal_q[TAP_HI] ^ chal_q[TAP_LO]};

    // Sequencing of evaluations, vote accumulation, bit packing and word handshake
    always_comb begin
        state_d   = state_q;
        chal_d    = chal_q;
        cyc_d     = cyc_q;
        eval_d    = eval_q;
        vote_d    = vote_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d    = (seed == '0) ? '1 : seed;
                    cyc_d     = '0;
                    eval_d    = '0;
                    vote_d    = '0;
                    bit_idx_d = '0;
                    data_d    = '0;
                    state_d   = ST_RISE;
                end
            end
            ST_RISE: begin
                if (cyc_q == RISE_LAST) begin
                    cyc_d   = '0;
                    if (arb_sync) begin
                        vote_d = vote_q + VOTE_W'(1);
                    end
                    state_d = ST_FALL;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_FALL: begin
                if (cyc_q == FALL_LAST) begin
                    cyc_d = '0;
                    if (eval_q == EVAL_LAST) begin
                        eval_d  = '0;
                        state_d = ST_PACK;
                    end else begin
                        eval_d  = eval_q + VOTE_W'(1);
                        state_d = ST_RISE;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_PACK: begin
                data_d[bit_idx_q] = (vote_q > MAJORITY);
                vote_d            = '0;
                chal_d            = lfsr_next;
                if (bit_idx_q == BIDX_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    bit_idx_d = bit_idx_q + BIDX_W'(1);
                    state_d   = ST_RISE;
                end
            end
            ST_OUT: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            chal_q    <= '0;
            cyc_q     <= '0;
            eval_q    <= '0;
            vote_q    <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            chal_q    <= chal_d;
            cyc_q     <= cyc_d;
            eval_q    <= eval_d;
            vote_q    <= vote_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
        end
    end

    assign chal_out   = chal_q;
    assign launch     = (state_q == ST_RISE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_OUT);
    assign resp_data  = data_q;

`ifdef PUF_RESP_STABILITY_EN
    logic [7:0] unstable_q, unstable_d;

    // Count challenges whose vote was split; cleared on a new word, saturating
    always_comb begin
        unstable_d = unstable_q;
        if (state_q == ST_IDLE && start) begin
            unstable_d = '0;
        end else if (state_q == ST_PACK && vote_q != '0 && vote_q != VOTE_ALL &&
                     unstable_q != UNSTABLE_MAX) begin
            unstable_d = unstable_q + 8'd1;
        end
    end

    // Instability counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unstable_q <= '0;
        end else begin
            unstable_q <= unstable_d;
        end
    end

    assign unstable_cnt = unstable_q;
`endif

endmodule

// File: tb/tb_puf_response_collector.sv
// Self-checking bench for puf_response_collector at default parameters.
// Directed vector table for whole-word runs plus hand sequences for seed
// substitution, LFSR stepping, output back-pressure and mid-run reset.
module tb_puf_response_collector;

    localparam int CHAL_W     = 65;
    localparam int RESP_BITS  = 32;
    localparam int EXP_LAT    = 2273;
    localparam int MAX_WAIT   = 3000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [CHAL_W-1:0]    seed;
    logic [CHAL_W-1:0]    chal_out;
    logic                 launch;
    logic                 arb_in;
    logic                 busy;
    logic [RESP_BITS-1:0] resp_data;
    logic                 resp_valid;
    logic                 resp_ready;
`ifdef PUF_RESP_STABILITY_EN
    logic [7:0]           unstable_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Arbiter behaviour selector: 0 always 1, 1 always 0, 2 three of seven, 3 four of seven
    logic [1:0] arb_mode;
    int         launch_cnt;

    typedef struct {
        logic [CHAL_W-1:0]    vseed;
        logic [1:0]           mode;
        logic                 early_ready;
        logic [RESP_BITS-1:0] exp_data;
        logic [7:0]           exp_unstable;
    } vec_t;

    vec_t vecs[4];

    puf_response_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .chal_out   (chal_out),
        .launch     (launch),
        .arb_in     (arb_in),
        .busy       (busy),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
`ifdef PUF_RESP_STABILITY_EN
        ,
        .unstable_cnt (unstable_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Arbiter model: a new decision is presented at every launch edge and held for the evaluation
    always @(posedge launch) begin
        case (arb_mode)
            2'd0: arb_in = 1'b1;
            2'd1: arb_in = 1'b0;
            2'd2: arb_in = ((launch_cnt % 7) < 3);
            default: arb_in = ((launch_cnt % 7) < 4);
        endcase
        launch_cnt = launch_cnt + 1;
    end

    function automatic logic [CHAL_W-1:0] lfsr_ref(input logic [CHAL_W-1:0] x);
        return {x[63:0], x[64] ^ x[46]};
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one clock with the given seed; returns just after the sampling edge
    task automatic apply_stimulus(input logic [CHAL_W-1:0] s, input logic [1:0] mode);
        @(negedge clk);
        arb_mode   = mode;
        launch_cnt = 0;
        seed       = s;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advance one negedge at a time until resp_valid, bounded
    task automatic wait_valid(inout int cyc);
        while (!resp_valid && cyc < MAX_WAIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Accept the word and confirm the collector returns to idle
    task automatic finish_word(input string name);
        resp_ready = 1'b1;
        @(negedge clk);
        check_output({name, "_busy_after"}, 128'(busy), 128'(0));
        check_output({name, "_valid_after"}, 128'(resp_valid), 128'(0));
        resp_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int hold_err;
        logic [CHAL_W-1:0] ones;
        logic [CHAL_W-1:0] chal_exp;

        ones       = '1;
        rst_n      = 1'b0;
        start      = 1'b0;
        seed       = '0;
        resp_ready = 1'b0;
        arb_in     = 1'b0;
        arb_mode   = 2'd0;
        launch_cnt = 0;

        vecs[0] = '{vseed: 65'h1,                    mode: 2'd0, early_ready: 1'b0,
                    exp_data: 32'hFFFF_FFFF, exp_unstable: 8'd0};
        vecs[1] = '{vseed: 65'h1_2345_6789_ABCD_EF01, mode: 2'd1, early_ready: 1'b0,
                    exp_data: 32'h0000_0000, exp_unstable: 8'd0};
        vecs[2] = '{vseed: 65'h0_DEAD_BEEF_0000_0001, mode: 2'd2, early_ready: 1'b0,
                    exp_data: 32'h0000_0000, exp_unstable: 8'd32};
        vecs[3] = '{vseed: 65'h1_0000_0000_0000_0000, mode: 2'd3, early_ready: 1'b1,
                    exp_data: 32'hFFFF_FFFF, exp_unstable: 8'd32};

        // Reset state
        #12;
        check_output("rst_busy", 128'(busy), 128'(0));
        check_output("rst_launch", 128'(launch), 128'(0));
        check_output("rst_valid", 128'(resp_valid), 128'(0));
        check_output("rst_data", 128'(resp_data), 128'(0));
        check_output("rst_chal", 128'(chal_out), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven full-word runs
        for (int i = 0; i < 4; i++) begin
            resp_ready = vecs[i].early_ready;
            apply_stimulus(vecs[i].vseed, vecs[i].mode);
            cyc = 0;
            wait_valid(cyc);
            check_output($sformatf("vec%0d_latency", i), 128'(cyc), 128'(EXP_LAT));
            check_output($sformatf("vec%0d_data", i), 128'(resp_data), 128'(vecs[i].exp_data));
`ifdef PUF_RESP_STABILITY_EN
            check_output($sformatf("vec%0d_unstable", i), 128'(unstable_cnt), 128'(vecs[i].exp_unstable));
`endif
            finish_word($sformatf("vec%0d", i));
        end

        // Zero seed becomes all-ones, held through the first challenge, then one LFSR step
        apply_stimulus('0, 2'd0);
        cyc = 0;
        @(negedge clk);
        cyc++;
        check_output("seed0_chal_first", 128'(chal_out), 128'(ones));
        check_output("seed0_launch_first", 128'(launch), 128'(1));
        check_output("seed0_busy", 128'(busy), 128'(1));
        repeat (69) begin
            @(negedge clk);
            cyc++;
        end
        check_output("seed0_chal_stable", 128'(chal_out), 128'(ones));
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        check_output("seed0_chal_step", 128'(chal_out), 128'(lfsr_ref(ones)));
        wait_valid(cyc);
        check_output("seed0_latency", 128'(cyc), 128'(EXP_LAT));
        finish_word("seed0");

        // Back-pressure: word held, start ignored, challenge reflects 32 LFSR steps
        apply_stimulus(65'h1, 2'd0);
        cyc = 0;
        wait_valid(cyc);
        check_output("hold_latency", 128'(cyc), 128'(EXP_LAT));
        chal_exp = 65'h1;
        for (int k = 0; k < RESP_BITS; k++) chal_exp = lfsr_ref(chal_exp);
        hold_err = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 10 || k == 30) begin
                seed  = 65'h5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF || chal_out !== chal_exp)
                hold_err++;
        end
        start = 1'b0;
        check_output("hold_stable_cycles_bad", 128'(hold_err), 128'(0));
        check_output("hold_chal_after_32", 128'(chal_out), 128'(chal_exp));
        finish_word("hold");
        repeat (3) @(negedge clk);
        check_output("hold_no_restart", 128'(busy), 128'(0));

        // Reset in the middle of the RISE phase of bit 5
        apply_stimulus(65'h3, 2'd0);
        cyc = 0;
        while (cyc < 358) begin
            @(negedge clk);
            cyc++;
        end
        check_output("midrst_in_rise", 128'(launch), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_launch", 128'(launch), 128'(0));
        check_output("midrst_busy", 128'(busy), 128'(0));
        check_output("midrst_chal", 128'(chal_out), 128'(0));
        check_output("midrst_data", 128'(resp_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(65'h7, 2'd3);
        cyc = 0;
        wait_valid(cyc);
        check_output("postrst_latency", 128'(cyc), 128'(EXP_LAT));
        check_output("postrst_data", 128'(resp_data), 128'(32'hFFFF_FFFF));
`ifdef PUF_RESP_STABILITY_EN
        check_output("postrst_unstable", 128'(unstable_cnt), 128'(32));
`endif
        finish_word("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
